// File: rtl/bram_burst_reader_if.sv
// bram_burst_reader_if: control, BRAM read and stream bundle for bram_burst_reader
// Ports (master = reader side):
//   start/start_addr/length/stop  burst command from the controller
//   ram_addr/ram_dout             BRAM read address out, read data back (1-cycle latency)
//   m_data/m_valid/m_ready/m_last valid/ready output stream with end-of-burst marker
//   busy/done                     burst status
interface bram_burst_reader_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32768,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic              stop;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_dout;
    logic [WIDTH-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;
    modport master (
        input  start, start_addr, length, stop, ram_dout, m_ready,
        output ram_addr, m_data, m_valid, m_last, busy, done
    );
    modport slave (
        output start, start_addr, length, stop, ram_dout, m_ready,
        input  ram_addr, m_data, m_valid, m_last, busy, done
    );
endinterface

// File: rtl/bram_burst_reader.sv
// bram_burst_reader: sweeps a BRAM address range (wrapping modulo DEPTH) and streams it out
// Ports: clk, rst (async, active-high), bus (bram_burst_reader_if.master).
// Optional: define BRAM_READER_LOOP_EN to repeat the burst until stop is requested.
module bram_burst_reader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32768,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    bram_burst_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              inflight_q, fl_last_q;
    logic              h_vld_q, h_last_q, s_vld_q, s_last_q;
    logic [WIDTH-1:0]  h_data_q, s_data_q;
    logic              busy_q, done_q;
`ifdef BRAM_READER_LOOP_EN
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic              stop_q;
`endif
    logic              pop, issue, is_last, h_take;
    logic [1:0]        occ_d;
    logic [ADDR_W-1:0] ptr_d;
    assign pop     = h_vld_q & bus.m_ready;
    // words held or in flight after this edge; keeps the 2-entry buffer from overflowing
    assign occ_d   = 2'(h_vld_q) + 2'(s_vld_q) + 2'(inflight_q) - 2'(pop);
    assign issue   = (state_q == RUN) && (rem_q != '0) && (occ_d < 2'd2);
    assign is_last = rem_q == LEN_W'(1);
    assign ptr_d   = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign h_take  = !h_vld_q || pop;
    assign bus.ram_addr = ptr_q;
    assign bus.m_data   = h_data_q;
    assign bus.m_valid  = h_vld_q;
    assign bus.m_last   = h_last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            fl_last_q  <= 1'b0;
            h_vld_q    <= 1'b0;
            h_last_q   <= 1'b0;
            h_data_q   <= '0;
            s_vld_q    <= 1'b0;
            s_last_q   <= 1'b0;
            s_data_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BRAM_READER_LOOP_EN
            base_q     <= '0;
            len_q      <= '0;
            stop_q     <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) fl_last_q <= is_last;
            // returning word goes to the head when it is free, otherwise to the second slot
            if (h_take) begin
                h_vld_q  <= s_vld_q | inflight_q;
                h_data_q <= s_vld_q ? s_data_q : bus.ram_dout;
                h_last_q <= s_vld_q ? s_last_q : fl_last_q;
            end
            s_vld_q <= h_take ? (s_vld_q & inflight_q) : (s_vld_q | inflight_q);
            if (inflight_q) begin
                s_data_q <= bus.ram_dout;
                s_last_q <= fl_last_q;
            end
`ifdef BRAM_READER_LOOP_EN
            if (busy_q && bus.stop) stop_q <= 1'b1;
`endif
            case (state_q)
                IDLE: if (bus.start) begin
                    if (bus.length == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        ptr_q   <= bus.start_addr;
                        rem_q   <= bus.length;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef BRAM_READER_LOOP_EN
                        base_q  <= bus.start_addr;
                        len_q   <= bus.length;
                        stop_q  <= 1'b0;
`endif
                    end
                end
                RUN: if (issue) begin
                    ptr_q <= ptr_d;
                    rem_q <= rem_q - 1'b1;
                    if (is_last) begin
`ifdef BRAM_READER_LOOP_EN
                        // a stop raised in this very cycle still ends the burst at this boundary
                        if (stop_q || bus.stop) begin
                            state_q <= DRAIN;
                        end else begin
                            ptr_q <= base_q;
                            rem_q <= len_q;
                        end
`else
                        state_q <= DRAIN;
`endif
                    end
                end
                DRAIN: if (pop && h_last_q) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_burst_reader.sv
// tb_bram_burst_reader: directed self-checking bench for bram_burst_reader (DEPTH=16)
module tb_bram_burst_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] mem [16];
    bram_burst_reader_if #(.WIDTH(32), .DEPTH(16)) bus ();
    bram_burst_reader #(.WIDTH(32), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    always #5 clk = ~clk;
    always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run_burst(input int a, input int n, input bit poke);
        bus.start = 1'b1;
        bus.start_addr = 4'(a);
        bus.length = 5'(n);
        tick();
        bus.start = 1'b0;
        chk("acc_busy", bus.busy, 1);
        chk("acc_valid", bus.m_valid, 0);
        tick();
        chk("lat_valid", bus.m_valid, 0);
        tick();
        for (int i = 0; i < n; i++) begin
            if (poke && i == 2) begin
                bus.start = 1'b1;
                bus.start_addr = 4'd0;
                bus.length = 5'd3;
            end else bus.start = 1'b0;
            chk("beat_valid", bus.m_valid, 1);
            chk("beat_data", bus.m_data, 32'hA000 + 32'((a + i) % 16));
            chk("beat_last", bus.m_last, (i == n - 1));
            chk("beat_busy", bus.busy, 1);
            chk("beat_done", bus.done, 0);
            tick();
        end
        bus.start = 1'b0;
        chk("end_done", bus.done, 1);
        chk("end_busy", bus.busy, 0);
        chk("end_valid", bus.m_valid, 0);
        tick();
        chk("done_once", bus.done, 0);
        chk("idle_valid", bus.m_valid, 0);
    endtask
    initial begin
        logic v, r, l;
        logic [31:0] d;
        int n;
        bit fin;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000 + 32'(i);
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.length = '0;
        bus.stop = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", 32'(bus.ram_addr), 0);
        rst = 1'b0;
        tick();
        run_burst(3, 5, 1'b0);
        run_burst(14, 4, 1'b0);
        // backpressure: random ready, words must arrive in order and hold while stalled
        bus.start = 1'b1;
        bus.start_addr = 4'd5;
        bus.length = 5'd8;
        tick();
        bus.start = 1'b0;
        n = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            v = bus.m_valid;
            r = bus.m_ready;
            d = bus.m_data;
            l = bus.m_last;
            if (v && r) begin
                chk("bp_data", d, 32'hA000 + 32'((5 + n) % 16));
                chk("bp_last", l, (n == 7));
                n++;
            end
            tick();
            if (v && !r) begin
                chk("bp_hold_valid", bus.m_valid, 1);
                chk("bp_hold_data", bus.m_data, d);
                chk("bp_hold_last", bus.m_last, l);
            end
            if (bus.done) fin = 1'b1;
        end
        chk("bp_count", n, 8);
        chk("bp_done", fin, 1);
        bus.m_ready = 1'b1;
        tick();
        // zero length: done pulse only
        bus.start = 1'b1;
        bus.length = 5'd0;
        tick();
        bus.start = 1'b0;
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        chk("zero_valid", bus.m_valid, 0);
        tick();
        chk("zero_done_once", bus.done, 0);
        chk("zero_valid2", bus.m_valid, 0);
        run_burst(9, 16, 1'b1);
        tick();
        chk("ignored_start_valid", bus.m_valid, 0);
        chk("ignored_start_busy", bus.busy, 0);
        // reset after 3 beats of an 8-word burst
        bus.start = 1'b1;
        bus.start_addr = 4'd0;
        bus.length = 5'd8;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("pre_rst_data", bus.m_data, 32'hA000 + 32'(i));
            tick();
        end
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.m_valid, 0);
        chk("arst_data", bus.m_data, 0);
        chk("arst_last", bus.m_last, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_addr", 32'(bus.ram_addr), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_valid", bus.m_valid, 0);
            tick();
        end
        run_burst(2, 4, 1'b0);
`ifdef BRAM_READER_LOOP_EN
        bus.start = 1'b1;
        bus.start_addr = 4'd0;
        bus.length = 5'd3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.stop = (i == 3);
            chk("loop_valid", bus.m_valid, 1);
            chk("loop_data", bus.m_data, 32'hA000 + 32'(i % 3));
            chk("loop_last", bus.m_last, (i % 3 == 2));
            chk("loop_done", bus.done, 0);
            tick();
        end
        bus.stop = 1'b0;
        chk("loop_end_done", bus.done, 1);
        chk("loop_end_busy", bus.busy, 0);
        tick();
        chk("loop_idle_valid", bus.m_valid, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
